stfwd_unit_mc: RTL and testbench
================================

// Module: stfwd_unit_mc
// PURPOSE
//  Parametrised store-to-load forwarding unit: store-queue entry array plus N_LD independent
//  forwarding channels, each acting as the slave side of the stfwd_if protocol (s0 vaddr CAM,
//  s1 match/data-ready check + paddr compare, s2 response). Per byte it picks the youngest store
//  older than the load. Sits between the load pipes and the store queue in the memfu backend.
// PARAMETERS
//  N_LD      2    number of load forwarding channels
//  SQ_DEPTH  16   store entries, power of 2; sqIdx = {flag, idx}, width SQW=$clog2(SQ_DEPTH)+1
//  XLEN      64   data width; byte lanes NB=XLEN/8, dword offset bits OB=$clog2(NB)
//  PADDR_W   39   physical address width
//  LQW       6    lqIdx width
// PORTS
//  clk            in   1            clock
//  rst            in   1            asynchronous reset, active-low
//  st_a_vld       in   1            store address write
//  st_a_idx       in   SQW-1        entry index
//  st_a_vaddr     in   XLEN         store vaddr
//  st_a_paddr     in   PADDR_W      store paddr
//  st_a_mask      in   NB           store byte mask, dword-aligned
//  st_d_vld       in   1            store data write
//  st_d_idx       in   SQW-1        entry index
//  st_d_data      in   XLEN         store data, byte-lane aligned
//  st_deq         in   1            retire head entry (written to sbuffer/cache)
//  head           out  SQW          current head pointer {flag,idx}
//  s0_vld         in   N_LD         per-channel request
//  s0_lqIdx       in   N_LD*LQW     load queue index
//  s0_sqIdx       in   N_LD*SQW     stores strictly before this pointer are older
//  s0_vaddr       in   N_LD*XLEN    load vaddr
//  s0_load_vec    in   N_LD*NB      load byte mask
//  s1_vld         in   N_LD         s1 still live
//  s1_paddr       in   N_LD*PADDR_W load paddr
//  s1_vaddr_match out  N_LD         any byte matched by vaddr
//  s1_data_rdy    out  N_LD         matched and all chosen entries have data
//  s2_rdy         out  N_LD         response valid
//  s2_lqIdx       out  N_LD*LQW     echoed lqIdx
//  s2_paddr_match out  N_LD         all chosen entries agree with s1_paddr
//  s2_match_failed out N_LD         load must replay
//  s2_match_vec   out  N_LD*NB      forwarded bytes
//  s2_fwd_data    out  N_LD*XLEN    forwarded bytes, 0 in unmatched lanes
// BEHAVIOUR
//  - Reset: all entries avld=dvld=0, head=0, all s1/s2 regs and every output 0.
//  - Entry: avld,dvld,vaddr,paddr,mask,data. st_a sets avld+fields; st_d sets dvld+data.
//    st_deq clears avld/dvld of head[idx], head+=1 (flag toggles on wrap). Same-cycle st_a/st_d to
//    a different entry than deq both take effect; write to head entry while st_deq=1 is illegal (assert).
//  - Older set: entries ptr p in [head, s0_sqIdx) modulo 2*SQ_DEPTH; s0_sqIdx==head -> empty;
//    flag differs and idx equal -> all SQ_DEPTH entries older.
//  - s0 (comb): hit(i)=older & avld & vaddr[XLEN-1:OB]==s0_vaddr[XLEN-1:OB]; per byte b with
//    load_vec[b]: sel[b]=youngest i (nearest s0_sqIdx-1) with hit & mask[b]. Registered at posedge:
//    s1 valid=s0_vld, lqIdx, byte hit vec, sel[b]; stale=0.
//  - s1 (comb from s1 regs + live entries): s1_vaddr_match=|hitvec; s1_data_rdy=match & all
//    dvld[sel[b]] for hit bytes. stale set if any selected entry dequeued in s0->s1 edge or in s1.
//    pmatch=all paddr[PADDR_W-1:OB] of chosen entries == s1_paddr[PADDR_W-1:OB] (1 if no hit).
//  - s2 (registered, 1 cycle after s1): s2_rdy=s1 valid & s1_vld; match_vec=hitvec;
//    fwd_data lane b = data[sel[b]] lane b (captured at s1); paddr_match=pmatch;
//    match_failed = hit & (!pmatch | !data_rdy | stale). s1_vld=0 kills s2 (s2_rdy=0).
//  - Latency: request s0 at cycle T -> s2 outputs valid in cycle T+2; fully pipelined, one
//    request per channel per cycle, channels independent and share entry array read-only.
//  - st_d in the same cycle as s1: data_rdy/data see pre-write state (write visible next cycle).
// TESTING
//  1 Reset mid-stream: rst=0 while s1/s2 busy -> all outputs 0 immediately; head=0 after release.
//  2 Single fwd: st entry 3 vaddr 0x1000 mask 0x0F data 0x..44332211, load sqIdx 4 vec 0xFF
//    vaddr 0x1000 -> T+2 s2_rdy=1, match_vec 0x0F, fwd_data 0x44332211, failed=0.
//  3 Youngest wins: entries 1,2 both mask 0x01 same dword, data lane0 0xAA/0xBB, sqIdx 3 ->
//    fwd lane0 0xBB; sqIdx 2 -> 0xAA; sqIdx 1 -> match_vec 0.
//  4 Wrap: head={0,14}, entries 14,15,0 valid, sqIdx={1,1} -> all three older; entry 0 chosen.
//  5 Failures: dvld=0 -> s1_data_rdy=0, failed=1; paddr differs -> paddr_match=0, failed=1;
//    st_deq of chosen entry during s1 -> failed=1.
//  6 Two channels same cycle, different addresses -> independent correct results; s1_vld=0 on
//    ch1 -> ch1 s2_rdy=0.

Source files
------------

// File: rtl/stfwd_unit_mc.sv
// Store-to-load forwarding: store-queue entry array plus N_LD
// independent three-stage (s0 CAM, s1 check, s2 response) load channels.
module stfwd_unit_mc #(
    parameter int N_LD     = 2,
    parameter int SQ_DEPTH = 16,
    parameter int XLEN     = 64,
    parameter int PADDR_W  = 39,
    parameter int LQW      = 6,
    localparam int SQW     = $clog2(SQ_DEPTH) + 1,
    localparam int IW      = SQW - 1,
    localparam int NB      = XLEN / 8,
    localparam int OB      = $clog2(NB)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_st_a_vld,
    input  logic [IW-1:0]          i_st_a_idx,
    input  logic [XLEN-1:0]        i_st_a_vaddr,
    input  logic [PADDR_W-1:0]     i_st_a_paddr,
    input  logic [NB-1:0]          i_st_a_mask,
    input  logic                   i_st_d_vld,
    input  logic [IW-1:0]          i_st_d_idx,
    input  logic [XLEN-1:0]        i_st_d_data,
    input  logic                   i_st_deq,
    output logic [SQW-1:0]         o_head,
    input  logic [N_LD-1:0]        i_s0_vld,
    input  logic [N_LD*LQW-1:0]    i_s0_lqIdx,
    input  logic [N_LD*SQW-1:0]    i_s0_sqIdx,
    input  logic [N_LD*XLEN-1:0]   i_s0_vaddr,
    input  logic [N_LD*NB-1:0]     i_s0_load_vec,
    input  logic [N_LD-1:0]        i_s1_vld,
    input  logic [N_LD*PADDR_W-1:0] i_s1_paddr,
    output logic [N_LD-1:0]        o_s1_vaddr_match,
    output logic [N_LD-1:0]        o_s1_data_rdy,
    output logic [N_LD-1:0]        o_s2_rdy,
    output logic [N_LD*LQW-1:0]    o_s2_lqIdx,
    output logic [N_LD-1:0]        o_s2_paddr_match,
    output logic [N_LD-1:0]        o_s2_match_failed,
    output logic [N_LD*NB-1:0]     o_s2_match_vec,
    output logic [N_LD*XLEN-1:0]   o_s2_fwd_data
);

    localparam int VW = XLEN - OB;
    localparam int PW = PADDR_W - OB;

    logic [SQ_DEPTH-1:0] r_avld;
    logic [SQ_DEPTH-1:0] r_dvld;
    logic [VW-1:0]       r_vaddr [SQ_DEPTH];
    logic [PW-1:0]       r_paddr [SQ_DEPTH];
    logic [NB-1:0]       r_mask  [SQ_DEPTH];
    logic [XLEN-1:0]     r_data  [SQ_DEPTH];
    logic [SQW-1:0]      r_head;
    logic [IW-1:0]       w_hidx;
    logic                w_unused;

    assign w_hidx = r_head[IW-1:0];
    assign o_head = r_head;
    assign w_unused = ^{i_st_a_vaddr[OB-1:0], i_st_a_paddr[OB-1:0]};

    // entry writes, then dequeue of the head entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_avld <= '0;
            r_dvld <= '0;
            r_head <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                r_vaddr[i] <= '0;
                r_paddr[i] <= '0;
                r_mask[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (i_st_a_vld) begin
                r_avld[i_st_a_idx]  <= 1'b1;
                r_vaddr[i_st_a_idx] <= i_st_a_vaddr[XLEN-1:OB];
                r_paddr[i_st_a_idx] <= i_st_a_paddr[PADDR_W-1:OB];
                r_mask[i_st_a_idx]  <= i_st_a_mask;
            end
            if (i_st_d_vld) begin
                r_dvld[i_st_d_idx] <= 1'b1;
                r_data[i_st_d_idx] <= i_st_d_data;
            end
            if (i_st_deq) begin
                r_avld[w_hidx] <= 1'b0;
                r_dvld[w_hidx] <= 1'b0;
                r_head <= r_head + SQW'(1);
            end
        end
    end

    a_no_head_write: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_st_deq |-> !(i_st_a_vld && i_st_a_idx == w_hidx)
                  && !(i_st_d_vld && i_st_d_idx == w_hidx));

    for (genvar c = 0; c < N_LD; c++) begin : g_ch
        logic [SQW-1:0]      w_sq;
        logic [XLEN-1:0]     w_va;
        logic [NB-1:0]       w_lv;
        logic [LQW-1:0]      w_lq;
        logic [PADDR_W-1:0]  w_pa;
        logic [SQW-1:0]      w_dist;
        logic [SQ_DEPTH-1:0] w_hit;
        logic [NB-1:0]       w_hv;
        logic [IW-1:0]       w_sel [NB];
        logic                w_stale0;
        logic                w_all;
        logic                w_pm;
        logic                w_st1;
        logic [XLEN-1:0]     w_fwd;
        logic                w_m;
        logic                w_go;
        logic                w_unused_lo;
        logic                r_s1_v;
        logic [LQW-1:0]      r_s1_lq;
        logic [NB-1:0]       r_s1_hv;
        logic [IW-1:0]       r_s1_sel [NB];
        logic                r_s1_stale;
        logic                r_s2_rdy;
        logic [LQW-1:0]      r_s2_lq;
        logic [NB-1:0]       r_s2_mv;
        logic [XLEN-1:0]     r_s2_fwd;
        logic                r_s2_pm;
        logic                r_s2_fail;

        assign w_sq   = i_s0_sqIdx[c*SQW +: SQW];
        assign w_va   = i_s0_vaddr[c*XLEN +: XLEN];
        assign w_lv   = i_s0_load_vec[c*NB +: NB];
        assign w_lq   = i_s0_lqIdx[c*LQW +: LQW];
        assign w_pa   = i_s1_paddr[c*PADDR_W +: PADDR_W];
        assign w_dist = w_sq - r_head;
        assign w_unused_lo = ^{w_va[OB-1:0], w_pa[OB-1:0]};

        // s0: vaddr CAM restricted to entries older than the load
        always_comb begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                w_hit[i] = ({1'b0, IW'(i) - w_hidx} < w_dist)
                         && r_avld[i]
                         && (r_vaddr[i] == w_va[XLEN-1:OB]);
            end
        end

        // s0: per byte keep the youngest hit (later age offsets overwrite)
        always_comb begin
            w_hv = '0;
            for (int b = 0; b < NB; b++) w_sel[b] = '0;
            for (int k = 0; k < SQ_DEPTH; k++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_lv[b] && w_hit[w_hidx + IW'(k)]
                        && r_mask[w_hidx + IW'(k)][b]) begin
                        w_hv[b]  = 1'b1;
                        w_sel[b] = w_hidx + IW'(k);
                    end
                end
            end
        end

        // s0: a chosen entry retiring on this edge makes the result stale
        always_comb begin
            w_stale0 = 1'b0;
            for (int b = 0; b < NB; b++) begin
                if (i_st_deq && w_hv[b] && w_sel[b] == w_hidx) w_stale0 = 1'b1;
            end
        end

        // s0 -> s1 capture
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_s1_v     <= 1'b0;
                r_s1_lq    <= '0;
                r_s1_hv    <= '0;
                r_s1_stale <= 1'b0;
                for (int b = 0; b < NB; b++) r_s1_sel[b] <= '0;
            end else begin
                r_s1_v     <= i_s0_vld[c];
                r_s1_lq    <= i_s0_vld[c] ? w_lq : '0;
                r_s1_hv    <= i_s0_vld[c] ? w_hv : '0;
                r_s1_stale <= i_s0_vld[c] & w_stale0;
                for (int b = 0; b < NB; b++) r_s1_sel[b] <= w_sel[b];
            end
        end

        // s1: data-ready, paddr and stale checks against live entries
        always_comb begin
            w_all = 1'b1;
            w_pm  = 1'b1;
            w_st1 = r_s1_stale;
            w_fwd = '0;
            for (int b = 0; b < NB; b++) begin
                if (r_s1_hv[b]) begin
                    if (!r_dvld[r_s1_sel[b]]) w_all = 1'b0;
                    if (r_paddr[r_s1_sel[b]] != w_pa[PADDR_W-1:OB]) w_pm = 1'b0;
                    if (i_st_deq && r_s1_sel[b] == w_hidx) w_st1 = 1'b1;
                    w_fwd[b*8 +: 8] = r_data[r_s1_sel[b]][b*8 +: 8];
                end
            end
        end

        assign w_m  = r_s1_v & (|r_s1_hv);
        assign w_go = r_s1_v & i_s1_vld[c];
        assign o_s1_vaddr_match[c] = w_m;
        assign o_s1_data_rdy[c]    = w_m & w_all;

        // s1 -> s2 response; a killed s1 leaves every s2 field at zero
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_s2_rdy  <= 1'b0;
                r_s2_lq   <= '0;
                r_s2_mv   <= '0;
                r_s2_fwd  <= '0;
                r_s2_pm   <= 1'b0;
                r_s2_fail <= 1'b0;
            end else begin
                r_s2_rdy  <= w_go;
                r_s2_lq   <= w_go ? r_s1_lq : '0;
                r_s2_mv   <= w_go ? r_s1_hv : '0;
                r_s2_fwd  <= w_go ? w_fwd : '0;
                r_s2_pm   <= w_go & w_pm;
                r_s2_fail <= w_go & (|r_s1_hv) & (~w_pm | ~w_all | w_st1);
            end
        end

        assign o_s2_rdy[c]               = r_s2_rdy;
        assign o_s2_lqIdx[c*LQW +: LQW]  = r_s2_lq;
        assign o_s2_match_vec[c*NB +: NB] = r_s2_mv;
        assign o_s2_fwd_data[c*XLEN +: XLEN] = r_s2_fwd;
        assign o_s2_paddr_match[c]       = r_s2_pm;
        assign o_s2_match_failed[c]      = r_s2_fail;
    end

endmodule

// File: tb/tb_stfwd_unit_mc.sv
// Bench for stfwd_unit_mc: directed vector table, corner sequences and
// random traffic against an age-walk reference model.
module tb_stfwd_unit_mc;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic st_a_vld, st_d_vld, st_deq;
    logic [3:0] st_a_idx, st_d_idx;
    logic [63:0] st_a_va, st_d_data;
    logic [38:0] st_a_pa;
    logic [7:0] st_a_mask;
    logic [4:0] head;
    logic [1:0] s0_vld, s1_vld;
    logic [1:0][5:0] s0_lq;
    logic [1:0][4:0] s0_sq;
    logic [1:0][63:0] s0_va;
    logic [1:0][7:0] s0_lv;
    logic [1:0][38:0] s1_pa;
    logic [1:0] vm, dr, s2_rdy, s2_pm, s2_fail;
    logic [1:0][5:0] s2_lq;
    logic [1:0][7:0] s2_mv;
    logic [1:0][63:0] s2_fwd;

    stfwd_unit_mc dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_st_a_vld(st_a_vld), .i_st_a_idx(st_a_idx), .i_st_a_vaddr(st_a_va),
        .i_st_a_paddr(st_a_pa), .i_st_a_mask(st_a_mask),
        .i_st_d_vld(st_d_vld), .i_st_d_idx(st_d_idx), .i_st_d_data(st_d_data),
        .i_st_deq(st_deq), .o_head(head),
        .i_s0_vld(s0_vld), .i_s0_lqIdx(s0_lq), .i_s0_sqIdx(s0_sq),
        .i_s0_vaddr(s0_va), .i_s0_load_vec(s0_lv),
        .i_s1_vld(s1_vld), .i_s1_paddr(s1_pa),
        .o_s1_vaddr_match(vm), .o_s1_data_rdy(dr),
        .o_s2_rdy(s2_rdy), .o_s2_lqIdx(s2_lq), .o_s2_paddr_match(s2_pm),
        .o_s2_match_failed(s2_fail), .o_s2_match_vec(s2_mv), .o_s2_fwd_data(s2_fwd)
    );

    logic m_av [D];
    logic m_dv [D];
    logic m_dk [D];
    logic [63:0] m_va [D];
    logic [38:0] m_pa [D];
    logic [7:0] m_mask [D];
    logic [63:0] m_data [D];
    int m_head;

    typedef struct packed {
        logic v; logic [5:0] lq; logic [7:0] hv; logic [7:0][3:0] sel; logic st;
    } ms1_t;
    typedef struct packed {
        logic rdy; logic [5:0] lq; logic [7:0] mv; logic pm; logic fl;
        logic [63:0] fwd; logic [63:0] fm;
    } ms2_t;
    ms1_t m1 [2];
    ms2_t m2 [2];

    typedef struct {
        logic [4:0] sq; logic [63:0] va; logic [7:0] lv;
        logic [7:0] mv; logic [63:0] fwd;
    } vec_t;
    vec_t tbl [8];

    int errors = 0;
    int checks = 0;
    int lqc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < D; i++) begin
            m_av[i] = 0; m_dv[i] = 0; m_dk[i] = 0;
            m_va[i] = '0; m_pa[i] = '0; m_mask[i] = '0; m_data[i] = '0;
        end
        m_head = 0;
        m1[0] = '0; m1[1] = '0; m2[0] = '0; m2[1] = '0;
    endtask

    // walk the age window from head towards sqIdx; the last hit per byte wins
    function automatic void m_s0(input logic [4:0] sq, input logic [63:0] va,
                                 input logic [7:0] lv, output logic [7:0] hv,
                                 output logic [7:0][3:0] sel);
        int p, n, i;
        p = m_head; n = 0; hv = '0; sel = '0;
        while (p != int'(sq) && n < D) begin
            i = p % D;
            if (m_av[i] && m_va[i][63:3] == va[63:3])
                for (int b = 0; b < 8; b++)
                    if (lv[b] && m_mask[i][b]) begin hv[b] = 1; sel[b] = 4'(i); end
            p = (p + 1) % (2 * D);
            n++;
        end
    endfunction

    task automatic idle();
        st_a_vld = 0; st_d_vld = 0; st_deq = 0;
        st_a_idx = 0; st_d_idx = 0; st_a_va = 0; st_a_pa = 0; st_a_mask = 0; st_d_data = 0;
        s0_vld = 0; s0_lq = '0; s0_sq = '0; s0_va = '0; s0_lv = '0;
        s1_vld = 2'b11; s1_pa = '0;
    endtask

    // one clock: s1 checks before the edge, model update, s2 checks after
    task automatic cycle();
        logic [7:0] hv0; logic [7:0][3:0] sel0;
        ms1_t n1 [2]; ms2_t n2 [2];
        logic all, pm, st, mt; logic [63:0] fwd, fm;
        int hi, i;
        #1;
        hi = m_head % D;
        for (int c = 0; c < 2; c++) begin
            m_s0(s0_sq[c], s0_va[c], s0_lv[c], hv0, sel0);
            n1[c] = '0;
            n1[c].v = s0_vld[c];
            if (s0_vld[c]) begin
                n1[c].lq = s0_lq[c]; n1[c].hv = hv0;
                for (int b = 0; b < 8; b++)
                    if (st_deq && hv0[b] && int'(sel0[b]) == hi) n1[c].st = 1;
            end
            n1[c].sel = sel0;
            all = 1; pm = 1; st = m1[c].st; fwd = 0; fm = 0;
            for (int b = 0; b < 8; b++) if (m1[c].hv[b]) begin
                i = int'(m1[c].sel[b]);
                if (!m_dv[i]) all = 0;
                if (m_pa[i][38:3] != s1_pa[c][38:3]) pm = 0;
                if (st_deq && i == hi) st = 1;
                fwd[b*8 +: 8] = m_data[i][b*8 +: 8];
                if (m_dk[i]) fm[b*8 +: 8] = 8'hFF;
            end
            mt = m1[c].v && (|m1[c].hv);
            chk($sformatf("s1_vaddr_match[%0d]", c), 64'(vm[c]), 64'(mt));
            chk($sformatf("s1_data_rdy[%0d]", c), 64'(dr[c]), 64'(mt && all));
            n2[c] = '0;
            if (m1[c].v && s1_vld[c]) begin
                n2[c].rdy = 1; n2[c].lq = m1[c].lq; n2[c].mv = m1[c].hv;
                n2[c].pm = pm; n2[c].fl = (|m1[c].hv) && (!pm || !all || st);
                n2[c].fwd = fwd; n2[c].fm = n2[c].mv == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : fm;
            end else n2[c].fm = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        @(posedge clk);
        if (st_a_vld) begin
            m_av[st_a_idx] = 1; m_va[st_a_idx] = st_a_va;
            m_pa[st_a_idx] = st_a_pa; m_mask[st_a_idx] = st_a_mask;
        end
        if (st_d_vld) begin
            m_dv[st_d_idx] = 1; m_dk[st_d_idx] = 1; m_data[st_d_idx] = st_d_data;
        end
        if (st_deq) begin
            m_av[hi] = 0; m_dv[hi] = 0; m_head = (m_head + 1) % (2 * D);
        end
        m1 = n1; m2 = n2;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("s2_rdy[%0d]", c), 64'(s2_rdy[c]), 64'(m2[c].rdy));
            chk($sformatf("s2_lqIdx[%0d]", c), 64'(s2_lq[c]), 64'(m2[c].lq));
            chk($sformatf("s2_match_vec[%0d]", c), 64'(s2_mv[c]), 64'(m2[c].mv));
            chk($sformatf("s2_paddr_match[%0d]", c), 64'(s2_pm[c]), 64'(m2[c].pm));
            chk($sformatf("s2_match_failed[%0d]", c), 64'(s2_fail[c]), 64'(m2[c].fl));
            chk($sformatf("s2_fwd_data[%0d]", c), s2_fwd[c] & m2[c].fm, m2[c].fwd & m2[c].fm);
        end
        chk("head", 64'(head), 64'(m_head));
        @(negedge clk);
    endtask

    task automatic st_wr(input int idx, input logic [63:0] va, input logic [7:0] mk,
                         input logic [63:0] d, input bit wd);
        st_a_vld = 1; st_a_idx = 4'(idx); st_a_va = va; st_a_pa = va[38:0]; st_a_mask = mk;
        st_d_vld = wd; st_d_idx = 4'(idx); st_d_data = d;
        cycle();
        st_a_vld = 0; st_d_vld = 0;
    endtask

    task automatic deq(input int n);
        st_deq = 1;
        repeat (n) cycle();
        st_deq = 0;
    endtask

    task automatic ld(input int c, input logic [4:0] sq, input logic [63:0] va,
                      input logic [7:0] lv, input logic [38:0] pa, input logic sv,
                      input logic dq);
        s0_vld[c] = 1; s0_sq[c] = sq; s0_va[c] = va; s0_lv[c] = lv;
        s0_lq[c] = 6'(lqc); lqc++;
        cycle();
        s0_vld[c] = 0; s1_vld[c] = sv; s1_pa[c] = pa; st_deq = dq;
        cycle();
        st_deq = 0; s1_vld[c] = 1;
    endtask

    initial begin
        logic [63:0] lva [2];
        logic [63:0] pool [3];
        int hi;
        tbl[0] = '{5'd4, 64'h1000, 8'hFF, 8'h0F, 64'h44332211};
        tbl[1] = '{5'd3, 64'h2000, 8'hFF, 8'h01, 64'hBB};
        tbl[2] = '{5'd2, 64'h2000, 8'hFF, 8'h01, 64'hAA};
        tbl[3] = '{5'd1, 64'h2000, 8'hFF, 8'h00, 64'h0};
        tbl[4] = '{5'd4, 64'h1004, 8'hF0, 8'h00, 64'h0};
        tbl[5] = '{5'd4, 64'h1008, 8'hFF, 8'h00, 64'h0};
        tbl[6] = '{5'd4, 64'h2000, 8'h03, 8'h01, 64'hBB};
        tbl[7] = '{5'd0, 64'h1000, 8'hFF, 8'h00, 64'h0};
        pool[0] = 64'h1000; pool[1] = 64'h1008; pool[2] = 64'h2000;

        idle();
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset_head", 64'(head), 64'h0);
        chk("reset_s2_rdy", 64'(s2_rdy), 64'h0);
        chk("reset_s1_match", 64'(vm), 64'h0);
        rst_n = 1;

        st_wr(1, 64'h2000, 8'h01, 64'hAA, 1);
        st_wr(2, 64'h2000, 8'h01, 64'hBB, 1);
        st_wr(3, 64'h1000, 8'h0F, 64'h8877665544332211, 1);
        for (int t = 0; t < 8; t++) begin
            ld(0, tbl[t].sq, tbl[t].va, tbl[t].lv, tbl[t].va[38:0], 1, 0);
            chk($sformatf("tbl%0d_rdy", t), 64'(s2_rdy[0]), 64'h1);
            chk($sformatf("tbl%0d_mv", t), 64'(s2_mv[0]), 64'(tbl[t].mv));
            chk($sformatf("tbl%0d_fwd", t), s2_fwd[0], tbl[t].fwd);
            chk($sformatf("tbl%0d_failed", t), 64'(s2_fail[0]), 64'h0);
        end

        st_wr(4, 64'h3000, 8'hFF, 64'h0, 0);
        s0_vld[0] = 1; s0_sq[0] = 5'd5; s0_va[0] = 64'h3000; s0_lv[0] = 8'hFF;
        cycle();
        s0_vld[0] = 0; s1_pa[0] = 39'h3000;
        #1;
        chk("nodata_s1_match", 64'(vm[0]), 64'h1);
        chk("nodata_s1_rdy", 64'(dr[0]), 64'h0);
        cycle();
        chk("nodata_failed", 64'(s2_fail[0]), 64'h1);
        chk("nodata_mv", 64'(s2_mv[0]), 64'hFF);

        ld(0, 5'd4, 64'h1000, 8'hFF, 39'h5000, 1, 0);
        chk("pdiff_pm", 64'(s2_pm[0]), 64'h0);
        chk("pdiff_failed", 64'(s2_fail[0]), 64'h1);

        deq(1);
        ld(0, 5'd2, 64'h2000, 8'hFF, 39'h2000, 1, 1);
        chk("deq_s1_mv", 64'(s2_mv[0]), 64'h01);
        chk("deq_s1_failed", 64'(s2_fail[0]), 64'h1);

        s0_vld = 2'b11; s0_sq[0] = 5'd4; s0_va[0] = 64'h1000; s0_lv[0] = 8'hFF;
        s0_sq[1] = 5'd4; s0_va[1] = 64'h1000; s0_lv[1] = 8'h0F;
        s1_pa[0] = 39'h1000; s1_pa[1] = 39'h1000;
        cycle();
        cycle();
        chk("busy_s2_rdy", 64'(s2_rdy[0]), 64'h1);
        chk("busy_s2_mv", 64'(s2_mv[0]), 64'h0F);
        #2 rst_n = 0;
        #1;
        chk("rst_s1_match", 64'(vm), 64'h0);
        chk("rst_s1_rdy", 64'(dr), 64'h0);
        chk("rst_s2_rdy", 64'(s2_rdy), 64'h0);
        chk("rst_s2_mv", 64'(s2_mv), 64'h0);
        chk("rst_s2_fwd", 64'(s2_fwd[0] | s2_fwd[1]), 64'h0);
        chk("rst_s2_fail_pm_lq", 64'({s2_fail, s2_pm, s2_lq}), 64'h0);
        chk("rst_head", 64'(head), 64'h0);
        idle();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        deq(14);
        chk("wrap_head", 64'(head), 64'd14);
        st_wr(14, 64'h4000, 8'h01, 64'h11, 1);
        st_wr(15, 64'h4000, 8'h01, 64'h22, 1);
        st_wr(0, 64'h4000, 8'h01, 64'h33, 1);
        ld(0, 5'b10001, 64'h4000, 8'h01, 39'h4000, 1, 0);
        chk("wrap_mv", 64'(s2_mv[0]), 64'h01);
        chk("wrap_fwd", s2_fwd[0], 64'h33);

        st_wr(1, 64'h6000, 8'hF0, 64'hDDCCBBAA_00000000, 1);
        for (int r = 0; r < 2; r++) begin
            s0_vld = 2'b11;
            s0_sq[0] = 5'd17; s0_va[0] = 64'h4000; s0_lv[0] = 8'hFF; s0_lq[0] = 6'd10;
            s0_sq[1] = 5'd18; s0_va[1] = 64'h6000; s0_lv[1] = 8'hFF; s0_lq[1] = 6'd20;
            cycle();
            s0_vld = 0; s1_pa[0] = 39'h4000; s1_pa[1] = 39'h6000;
            s1_vld = (r == 0) ? 2'b11 : 2'b01;
            cycle();
            s1_vld = 2'b11;
            chk($sformatf("dual%0d_ch0_mv", r), 64'(s2_mv[0]), 64'h01);
            chk($sformatf("dual%0d_ch0_fwd", r), s2_fwd[0], 64'h33);
            chk($sformatf("dual%0d_ch0_lq", r), 64'(s2_lq[0]), 64'd10);
            chk($sformatf("dual%0d_ch1_rdy", r), 64'(s2_rdy[1]), (r == 0) ? 64'h1 : 64'h0);
            chk($sformatf("dual%0d_ch1_mv", r), 64'(s2_mv[1]), (r == 0) ? 64'hF0 : 64'h0);
            chk($sformatf("dual%0d_ch1_fwd", r), s2_fwd[1], (r == 0) ? 64'hDDCCBBAA_00000000 : 64'h0);
        end

        lva[0] = 0; lva[1] = 0;
        for (int n = 0; n < 400; n++) begin
            hi = m_head % D;
            st_deq = ($urandom % 5) == 0;
            st_a_vld = ($urandom % 3) == 0;
            st_a_idx = 4'($urandom);
            st_a_va = pool[$urandom % 3] | 64'($urandom % 8);
            st_a_pa = st_a_va[38:0] ^ ((($urandom % 8) == 0) ? 39'h40 : 39'h0);
            st_a_mask = 8'($urandom);
            if (st_deq && int'(st_a_idx) == hi) st_a_vld = 0;
            st_d_vld = ($urandom % 3) == 0;
            st_d_idx = 4'($urandom);
            st_d_data = {$urandom, $urandom};
            if (st_deq && int'(st_d_idx) == hi) st_d_vld = 0;
            for (int c = 0; c < 2; c++) begin
                s1_pa[c] = lva[c][38:0];
                s1_vld[c] = ($urandom % 8) != 0;
                s0_vld[c] = ($urandom % 4) != 0;
                s0_sq[c] = 5'((m_head + int'($urandom_range(0, 16))) % (2 * D));
                s0_va[c] = pool[$urandom % 3] | 64'($urandom % 8);
                s0_lv[c] = 8'($urandom);
                s0_lq[c] = 6'($urandom);
                lva[c] = s0_va[c];
            end
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
